vga_timing_gen: RTL

//  Produces VGA 640x480@60 raster timing: hcount/vcount, hsync/vsync and display_pixel.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants shared by the VGA timing generator and its axis counters.
// Combinational constants only; no latency or backpressure.
package vga_timing_pkg;

   localparam int COUNT_W      = 10;
   localparam int VGA_CLK_DIV  = 2;

   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;

   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

   // Visible window, half-open [start, end)
   localparam int VGA_H_VIS_START = VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_VIS_END   = VGA_H_VIS_START + VGA_H_ACTIVE;
   localparam int VGA_V_VIS_START = VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_VIS_END   = VGA_V_VIS_START + VGA_V_ACTIVE;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one raster axis with registered sync/active decode of the next count.
// Decode flags line up with count in the same cycle; free-running on inc, no backpressure.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP,
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   output logic [COUNT_W-1:0] count,
   output logic               wrap,
   output logic               sync_n,
   output logic               active
);

   localparam int TOTAL = SYNC + BP + ACTIVE + FP;
   localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
   localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(SYNC);
   localparam logic [COUNT_W-1:0] VIS_LO   = COUNT_W'(SYNC + BP);
   localparam logic [COUNT_W-1:0] VIS_HI   = COUNT_W'(SYNC + BP + ACTIVE);

   logic [COUNT_W-1:0] count_nxt;

   assign wrap = inc && (count == LAST);

   always_comb begin
      count_nxt = count;
      if (wrap) begin
         count_nxt = '0;
      end else if (inc) begin
         count_nxt = count + COUNT_W'(1);
      end
   end

   // Decoding the next value keeps the flags in step with count, with no gap between ticks
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         sync_n <= 1'b0;
         active <= 1'b0;
      end else begin
         count  <= count_nxt;
         sync_n <= (count_nxt >= SYNC_END);
         active <= (count_nxt >= VIS_LO) && (count_nxt < VIS_HI);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (hcount/vcount, syncs, display_pixel, frame_start); VGA_FRAME_COUNT_EN adds frame_count.
// Outputs registered and mutually aligned, advancing one clk after each pix_tick; free-running, no backpressure.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               pix_tick,
   output logic [COUNT_W-1:0] hcount,
   output logic [COUNT_W-1:0] vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               display_pixel,
   output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [15:0]        frame_count
`endif
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
   end

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             h_wrap;
   logic             v_wrap;
   logic             h_active;
   logic             v_active;

   assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

   // pix_tick is looked ahead one clk so it is a clean register, high while div_cnt is at its last phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         pix_tick <= 1'b0;
      end else begin
         div_cnt  <= div_nxt;
         pix_tick <= (div_nxt == DIV_LAST);
      end
   end

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP)
   ) u_h (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (pix_tick),
      .count  (hcount),
      .wrap   (h_wrap),
      .sync_n (hsync),
      .active (h_active)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP)
   ) u_v (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (h_wrap),
      .count  (vcount),
      .wrap   (v_wrap),
      .sync_n (vsync),
      .active (v_active)
   );

   // Both flags are registers updated on the same edge, so their AND is stable all cycle
   assign display_pixel = h_active & v_active;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= v_wrap;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count <= '0;
      end else if (v_wrap) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule
